// File: rtl/ifu_redirect_ctrl.sv
// Next-PC sequencing controller: arbitrates redirect sources into the IFU
// next-PC select, generates pipeline flushes and owns the EXL state machine.
module ifu_redirect_ctrl #(
  parameter int unsigned EPC_SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       br_valid,
  input  logic       j_valid,
  input  logic       jr_valid,
  input  logic       exc_req,
  input  logic       int_req,
  input  logic       eret_req,
  output logic [3:0] choose_way,
  output logic       pc_en,
  output logic       flush_if_id,
  output logic       flush_all,
  output logic       exl,
  output logic [7:0] exc_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HANDLER   = 2'd1,
    ERET_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] WAY_SEQ     = 4'd0;
  localparam logic [3:0] WAY_BRANCH  = 4'd1;
  localparam logic [3:0] WAY_J       = 4'd2;
  localparam logic [3:0] WAY_JR      = 4'd3;
  localparam logic [3:0] WAY_HANDLER = 4'd4;
  localparam logic [3:0] WAY_EPC     = 4'd5;

  localparam logic [2:0] SETTLE_LOAD = 3'(EPC_SETTLE);

  state_e     state_q, state_d;
  logic [2:0] settle_q, settle_d;
  logic [7:0] exc_count_q, exc_count_d;
  logic       exl_q, exl_d;

  logic       taken;
  logic [3:0] seq_way;
  logic       seq_en;

  // Ordinary fetch path: stall freezes the PC, otherwise jr > j > branch > PC+4.
  always_comb begin
    seq_way = WAY_SEQ;
    seq_en  = 1'b0;
    if (!stall) begin
      seq_en = 1'b1;
      if (jr_valid)      seq_way = WAY_JR;
      else if (j_valid)  seq_way = WAY_J;
      else if (br_valid) seq_way = WAY_BRANCH;
      else               seq_way = WAY_SEQ;
    end
  end

  assign taken = exc_req | (int_req & ~exl_q);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    exc_count_d = exc_count_q;
    choose_way  = WAY_SEQ;
    pc_en       = 1'b0;
    flush_if_id = 1'b0;
    flush_all   = 1'b0;

    if (taken) begin
      choose_way = WAY_HANDLER;
      pc_en      = 1'b1;
      flush_all  = 1'b1;
      state_d    = HANDLER;
      settle_d   = 3'd0;
      if (exc_count_q != 8'hFF) exc_count_d = exc_count_q + 8'd1;
    end else begin
      unique case (state_q)
        HANDLER: begin
          if (eret_req) begin
            choose_way = WAY_EPC;
            flush_all  = 1'b1;
            settle_d   = SETTLE_LOAD;
            if (EPC_SETTLE == 0) begin
              pc_en   = 1'b1;
              state_d = RUN;
            end else begin
              state_d = ERET_WAIT;
            end
          end else begin
            choose_way = seq_way;
            pc_en      = seq_en;
          end
        end
        // Fetch is held on the EPC select until the settle count runs out.
        ERET_WAIT: begin
          choose_way  = WAY_EPC;
          flush_if_id = 1'b1;
          if (settle_q > 3'd1) begin
            settle_d = settle_q - 3'd1;
          end else begin
            pc_en    = 1'b1;
            settle_d = 3'd0;
            state_d  = RUN;
          end
        end
        default: begin
          choose_way = seq_way;
          pc_en      = seq_en;
        end
      endcase
    end

    if (!reset) begin
      choose_way  = WAY_SEQ;
      pc_en       = 1'b0;
      flush_if_id = 1'b0;
      flush_all   = 1'b0;
    end
  end

  assign exl_d = (state_d != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      settle_q    <= 3'd0;
      exc_count_q <= 8'd0;
      exl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      exc_count_q <= exc_count_d;
      exl_q       <= exl_d;
    end
  end

  assign exl       = exl_q;
  assign exc_count = exc_count_q;

endmodule

// File: tb/tb_ifu_redirect_ctrl.sv
// Directed bench for ifu_redirect_ctrl: a cycle-by-cycle vector table plus
// hand-written reset, saturation and abandoned-return sequences.
module tb_ifu_redirect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall, br_valid, j_valid, jr_valid, exc_req, int_req, eret_req;
  logic [3:0] choose_way;
  logic       pc_en, flush_if_id, flush_all, exl;
  logic [7:0] exc_count;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ifu_redirect_ctrl #(.EPC_SETTLE(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .j_valid(j_valid), .jr_valid(jr_valid), .exc_req(exc_req),
    .int_req(int_req), .eret_req(eret_req), .choose_way(choose_way),
    .pc_en(pc_en), .flush_if_id(flush_if_id), .flush_all(flush_all),
    .exl(exl), .exc_count(exc_count)
  );

  typedef struct {
    logic [6:0] in;   // {stall, br, j, jr, exc, int, eret}
    logic [3:0] cw;
    logic       pen;
    logic       fi;
    logic       fa;
    logic       exl;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[28];

  task automatic applyStimulus(input logic [6:0] in);
    {stall, br_valid, j_valid, jr_valid, exc_req, int_req, eret_req} = in;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] cw, input logic pen,
                          input logic fi, input logic fa, input logic ex, input logic [7:0] cnt);
    checkOutput({tag, ".choose_way"}, int'(choose_way), int'(cw));
    checkOutput({tag, ".pc_en"}, int'(pc_en), int'(pen));
    checkOutput({tag, ".flush_if_id"}, int'(flush_if_id), int'(fi));
    checkOutput({tag, ".flush_all"}, int'(flush_all), int'(fa));
    checkOutput({tag, ".exl"}, int'(exl), int'(ex));
    checkOutput({tag, ".exc_count"}, int'(exc_count), int'(cnt));
  endtask

  initial begin
    // input order: stall br j jr exc int eret
    vecs[0]  = '{7'b0000000, 4'd0, 1, 0, 0, 0, 8'd0};
    vecs[1]  = '{7'b0100000, 4'd1, 1, 0, 0, 0, 8'd0};
    vecs[2]  = '{7'b0010000, 4'd2, 1, 0, 0, 0, 8'd0};
    vecs[3]  = '{7'b0001000, 4'd3, 1, 0, 0, 0, 8'd0};
    vecs[4]  = '{7'b0111000, 4'd3, 1, 0, 0, 0, 8'd0};
    vecs[5]  = '{7'b1100000, 4'd0, 0, 0, 0, 0, 8'd0};
    vecs[6]  = '{7'b1010000, 4'd0, 0, 0, 0, 0, 8'd0};
    vecs[7]  = '{7'b1001000, 4'd0, 0, 0, 0, 0, 8'd0};
    vecs[8]  = '{7'b1111000, 4'd0, 0, 0, 0, 0, 8'd0};
    vecs[9]  = '{7'b0000001, 4'd0, 1, 0, 0, 0, 8'd0};  // eret in RUN ignored
    vecs[10] = '{7'b0000010, 4'd4, 1, 0, 1, 0, 8'd0};  // interrupt entry
    vecs[11] = '{7'b0000010, 4'd0, 1, 0, 0, 1, 8'd1};  // masked
    vecs[12] = '{7'b0000011, 4'd5, 0, 0, 1, 1, 8'd1};  // int+eret: eret wins
    vecs[13] = '{7'b0100010, 4'd5, 0, 1, 0, 1, 8'd1};  // settle, br ignored
    vecs[14] = '{7'b0000010, 4'd5, 1, 1, 0, 1, 8'd1};  // return edge
    vecs[15] = '{7'b0000010, 4'd4, 1, 0, 1, 0, 8'd1};  // int still high, taken
    vecs[16] = '{7'b0000000, 4'd0, 1, 0, 0, 1, 8'd2};
    vecs[17] = '{7'b0000101, 4'd4, 1, 0, 1, 1, 8'd2};  // exc+eret: exc wins
    vecs[18] = '{7'b0000001, 4'd5, 0, 0, 1, 1, 8'd3};
    vecs[19] = '{7'b1000000, 4'd5, 0, 1, 0, 1, 8'd3};  // stall ignored
    vecs[20] = '{7'b0000100, 4'd4, 1, 0, 1, 1, 8'd3};  // exc abandons return
    vecs[21] = '{7'b0000000, 4'd0, 1, 0, 0, 1, 8'd4};
    vecs[22] = '{7'b0000001, 4'd5, 0, 0, 1, 1, 8'd4};
    vecs[23] = '{7'b0000000, 4'd5, 0, 1, 0, 1, 8'd4};
    vecs[24] = '{7'b0000000, 4'd5, 1, 1, 0, 1, 8'd4};
    vecs[25] = '{7'b0000000, 4'd0, 1, 0, 0, 0, 8'd4};
    vecs[26] = '{7'b1000100, 4'd4, 1, 0, 1, 0, 8'd4};  // exc+stall
    vecs[27] = '{7'b0000000, 4'd0, 1, 0, 0, 1, 8'd5};

    // Reset held while inputs toggle
    reset = 1'b0;
    applyStimulus(7'b0000000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      applyStimulus(7'(i * 37 + 21));
      @(negedge clk);
      checkAll($sformatf("reset%0d", i), 4'd0, 0, 0, 0, 0, 8'd0);
    end

    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].in);
      @(negedge clk);
      checkAll($sformatf("vec%0d", i), vecs[i].cw, vecs[i].pen, vecs[i].fi,
               vecs[i].fa, vecs[i].exl, vecs[i].cnt);
      @(posedge clk); #1;
    end

    // Saturation from a clean reset
    reset = 1'b0;
    applyStimulus(7'b0000000);
    #2;
    checkAll("satreset", 4'd0, 0, 0, 0, 0, 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(7'b0000100);
    for (int i = 0; i < 260; i++) begin
      @(posedge clk); #1;
      if (i == 99) checkOutput("sat.count100", int'(exc_count), 100);
    end
    @(negedge clk);
    checkOutput("sat.count260", int'(exc_count), 255);
    checkOutput("sat.exl", int'(exl), 1);
    checkOutput("sat.pc_en", int'(pc_en), 1);
    #2;
    reset = 1'b0;
    #1;
    checkAll("sat.asyncreset", 4'd0, 0, 0, 0, 0, 8'd0);

    // Reset in the middle of ERET_WAIT discards the pending return
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(7'b0000010);
    @(posedge clk); #1;
    applyStimulus(7'b0000001);
    @(posedge clk); #1;
    applyStimulus(7'b0000000);
    @(negedge clk);
    checkAll("midwait", 4'd5, 0, 1, 0, 1, 8'd1);
    reset = 1'b0;
    #1;
    checkAll("midwait.reset", 4'd0, 0, 0, 0, 0, 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkAll("midwait.after", 4'd0, 1, 0, 0, 0, 8'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkAll("midwait.after2", 4'd0, 1, 0, 0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
